aes_key_expand: RTL

- AES-128 key-schedule stage that sits directly upstream of aes_core.
- On a start request it expands one 128-bit cipher key into round keys rk[0..NUM_ROUNDS], producing one round key per clock, and holds them in an internal register file.
- The core reads the round key it needs through a combinational index port.
- Replaces the core's current reuse of the raw key in every round.

---
 rtl/aes_pkg.sv | 52 +++++
 rtl/aes_key_expand_if.sv | 23 ++
 rtl/aes_sbox.sv | 32 +++
 rtl/aes_key_expand.sv | 111 +++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, round-constant table, key-expansion FSM
// states and the word-mixing step of the AES-128 key schedule.
package aes_pkg;

  localparam int AES_KEY_W      = 128;
  localparam int AES_MAX_ROUNDS = 10;

  typedef enum logic [0:0] {
    AES_KE_IDLE   = 1'b0,
    AES_KE_EXPAND = 1'b1
  } aes_ke_state_e;

  // Round constant for round 1..10; any other index yields 0.
  function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Chains the four words of the previous round key. sub_rot is
  // SubWord(RotWord(w3)) of that key, computed by the caller's S-boxes.
  function automatic logic [AES_KEY_W-1:0] aes_next_round_key(
    input logic [AES_KEY_W-1:0] prev,
    input logic [31:0]          sub_rot,
    input logic [7:0]           rc
  );
    logic [31:0] t;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] n3;
    t  = sub_rot ^ {rc, 24'h000000};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64]  ^ n0;
    n2 = prev[63:32]  ^ n1;
    n3 = prev[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Request/status/read-port bundle between the key schedule and its consumer.
interface aes_key_expand_if;
  import aes_pkg::*;

  logic [AES_KEY_W-1:0] key_in;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 keys_valid;
  logic [3:0]           rk_idx;
  logic [AES_KEY_W-1:0] rk_out;

  modport master (
    output key_in, start, rk_idx,
    input  busy, done, keys_valid, rk_out
  );

  modport slave (
    input  key_in, start, rk_idx,
    output busy, done, keys_valid, rk_out
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry for input value v occupies bits [2047-8v -: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] sel_s;

  assign sel_s    = 11'd2040 - {in_byte, 3'b000};
  assign out_byte = SBOX_TABLE[sel_s +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: expands one cipher key into rk[0..NUM_ROUNDS], one
// round key per clock, and serves them through a combinational read port.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int KEY_W      = AES_KEY_W,
  parameter int NUM_ROUNDS = AES_MAX_ROUNDS
) (
  input  logic             clk,
  input  logic             rst,
  aes_key_expand_if.slave  bus
);

  localparam logic [0:0] ST_IDLE   = AES_KE_IDLE;
  localparam logic [0:0] ST_EXPAND = AES_KE_EXPAND;
  localparam logic [3:0] LAST_RND  = 4'(NUM_ROUNDS);

  logic [0:0]       state_r;
  logic [3:0]       rnd_r;
  logic             busy_r;
  logic             done_r;
  logic             keys_valid_r;
  logic [KEY_W-1:0] last_rk_r;
  logic [KEY_W-1:0] rk_r [0:NUM_ROUNDS];

  logic [31:0]      rot_s;
  logic [31:0]      sub_s;
  logic [KEY_W-1:0] next_rk_s;
  logic [KEY_W-1:0] rk_rd_s;

  // RotWord of the last word of the most recently written round key.
  assign rot_s = {last_rk_r[23:0], last_rk_r[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (rot_s[8*b +: 8]),
      .out_byte (sub_s[8*b +: 8])
    );
  end

  assign next_rk_s = aes_next_round_key(last_rk_r, sub_s, aes_rcon(rnd_r));

  // Expansion sequencer and round-key register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      rnd_r        <= 4'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      keys_valid_r <= 1'b0;
      last_rk_r    <= {KEY_W{1'b0}};
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        rk_r[i] <= {KEY_W{1'b0}};
      end
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            rk_r[0]      <= bus.key_in;
            last_rk_r    <= bus.key_in;
            rnd_r        <= 4'd1;
            keys_valid_r <= 1'b0;
            busy_r       <= 1'b1;
            state_r      <= ST_EXPAND;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXPAND: begin
          // start is deliberately not looked at here: a running expansion
          // always finishes on the key it was started with.
          for (int i = 1; i <= NUM_ROUNDS; i++) begin
            if (rnd_r == 4'(i)) begin
              rk_r[i] <= next_rk_s;
            end
          end
          last_rk_r <= next_rk_s;
          rnd_r     <= rnd_r + 4'd1;
          if (rnd_r == LAST_RND) begin
            busy_r       <= 1'b0;
            keys_valid_r <= 1'b1;
            done_r       <= 1'b1;
            state_r      <= ST_IDLE;
          end else begin
            state_r <= ST_EXPAND;
          end
        end
        default: begin
          busy_r       <= 1'b0;
          keys_valid_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  // Indexed read; indices beyond the schedule select nothing and read 0.
  always_comb begin
    rk_rd_s = {KEY_W{1'b0}};
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      rk_rd_s = rk_rd_s | ((bus.rk_idx == 4'(i)) ? rk_r[i] : {KEY_W{1'b0}});
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.keys_valid = keys_valid_r;
  assign bus.rk_out     = rk_rd_s;

endmodule
